// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C responder.
// State encoding: bit 3 set marks an ACK-slot state, low bits name the byte phase.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'b0000,
        ADDR      = 4'b0001,
        RX_BYTE   = 4'b0010,
        TX_BYTE   = 4'b0011,
        WAIT_STOP = 4'b0100,
        ADDR_ACK  = 4'b1001,
        RX_ACK    = 4'b1010,
        TX_ACK    = 4'b1011
    } stateType_I2C_Slave;

    localparam logic [7:0] I2C_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins and local byte ports of the I2C responder.
// Local handshakes: o_RxValid/o_TxReq/o_TxUnderrun are single-cycle pulses; i_RxReady and i_TxValid are levels sampled at the moment the byte is consumed or loaded.
interface i2c_slave_if;

    logic       i_SCL;
    logic       i_SDA;
    logic       o_SDA_OE;
    logic [7:0] o_RxData;
    logic       o_RxValid;
    logic       i_RxReady;
    logic [7:0] i_TxData;
    logic       i_TxValid;
    logic       o_TxReq;
    logic       o_TxUnderrun;
    logic       o_Busy;

    modport slave (
        input  i_SCL, i_SDA, i_RxReady, i_TxData, i_TxValid,
        output o_SDA_OE, o_RxData, o_RxValid, o_TxReq, o_TxUnderrun, o_Busy
    );

    modport master (
        output i_SCL, i_SDA, i_RxReady, i_TxData, i_TxValid,
        input  o_SDA_OE, o_RxData, o_RxValid, o_TxReq, o_TxUnderrun, o_Busy
    );

endinterface

// File: rtl/i2c_slave_bus_sync.sv
// Synchronizes SCL/SDA into the system clock domain and flags SCL edges, START and STOP.
module i2c_bus_sync #(
    parameter int SyncStages = 2
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_SCL,
    input  logic i_SDA,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_sync,
    output logic start_det,
    output logic stop_det
);

    if (SyncStages < 2) begin : g_stage_check
        $error("i2c_bus_sync: SyncStages must be at least 2");
    end

    logic [SyncStages-1:0] scl_pipe;
    logic [SyncStages-1:0] sda_pipe;
    logic                  scl_d;
    logic                  sda_d;
    logic                  scl_s;
    logic                  sda_s;

    // Preset to 1 so a reset never looks like a START on an idle bus.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SyncStages-2:0], i_SCL};
            sda_pipe <= {sda_pipe[SyncStages-2:0], i_SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_pipe[SyncStages-1];
    assign sda_s     = sda_pipe[SyncStages-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign sda_sync  = sda_s;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C responder: fixed 7-bit address, open-drain SDA via output enable, no clock stretching.
// Write bytes go out on o_RxData/o_RxValid; read bytes come from i_TxData on o_TxReq.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int         DataWidth    = 8,
    parameter logic [6:0] SlaveAddress = 7'h50,
    parameter int         SyncStages   = 2
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic               i_ENABLE,
    i2c_slave_if.slave         bus,
    output stateType_I2C_Slave o_State
);

    if (DataWidth != 8) begin : g_width_check
        $error("i2c_slave: DataWidth must be 8");
    end

    logic scl_rise, scl_fall, sda_sync, start_det, stop_det;

    i2c_bus_sync #(.SyncStages(SyncStages)) u_sync (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .i_SCL     (bus.i_SCL),
        .i_SDA     (bus.i_SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_sync  (sda_sync),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    stateType_I2C_Slave state_q, state_n;
    logic [2:0] bit_cnt_q, bit_cnt_n;
    logic [6:0] shift_q, shift_n;
    logic [6:0] tx_shift_q, tx_shift_n;
    logic       rw_q, rw_n;
    logic       ack_q, ack_n;
    logic       slot_q, slot_n;
    logic       matched_q, matched_n;
    logic       oe_q, oe_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       rx_valid_q, rx_valid_n;
    logic       tx_req_q, tx_req_n;
    logic       underrun_q, underrun_n;
    logic [7:0] tx_next;

    assign tx_next = bus.i_TxValid ? bus.i_TxData : I2C_IDLE_BYTE;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            slot_q     <= 1'b0;
            matched_q  <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            shift_q    <= shift_n;
            tx_shift_q <= tx_shift_n;
            rw_q       <= rw_n;
            ack_q      <= ack_n;
            slot_q     <= slot_n;
            matched_q  <= matched_n;
            oe_q       <= oe_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            tx_req_q   <= tx_req_n;
            underrun_q <= underrun_n;
        end
    end

    // slot_q: inside an ACK state, 0 = waiting for the fall that drives the slot, 1 = waiting for the fall that ends it.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        shift_n    = shift_q;
        tx_shift_n = tx_shift_q;
        rw_n       = rw_q;
        ack_n      = ack_q;
        slot_n     = slot_q;
        matched_n  = matched_q;
        oe_n       = oe_q;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        underrun_n = 1'b0;
        if (!i_ENABLE || stop_det || start_det) begin
            state_n   = (i_ENABLE && start_det && !stop_det) ? ADDR : IDLE;
            bit_cnt_n = '0;
            slot_n    = 1'b0;
            matched_n = 1'b0;
            oe_n      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_n   = {shift_q[5:0], sda_sync};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_n   = sda_sync;
                        slot_n = 1'b0;
                        if (shift_q == SlaveAddress) begin
                            state_n   = ADDR_ACK;
                            matched_n = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!slot_q) begin
                        oe_n     = 1'b1;
                        slot_n   = 1'b1;
                        tx_req_n = rw_q;
                    end else begin
                        slot_n    = 1'b0;
                        bit_cnt_n = '0;
                        if (rw_q) begin
                            tx_shift_n = tx_next[6:0];
                            oe_n       = ~tx_next[7];
                            underrun_n = ~bus.i_TxValid;
                            state_n    = TX_BYTE;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_n   = {shift_q[5:0], sda_sync};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ack_n   = bus.i_RxReady;
                        slot_n  = 1'b0;
                        state_n = RX_ACK;
                        if (bus.i_RxReady) begin
                            rx_data_n  = {shift_q, sda_sync};
                            rx_valid_n = 1'b1;
                        end
                    end
                end
                RX_ACK: if (scl_fall) begin
                    if (!slot_q) begin
                        oe_n   = ack_q;
                        slot_n = 1'b1;
                    end else begin
                        oe_n      = 1'b0;
                        slot_n    = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = RX_BYTE;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        oe_n      = 1'b0;
                        bit_cnt_n = '0;
                        tx_req_n  = 1'b1;
                        slot_n    = 1'b0;
                        state_n   = TX_ACK;
                    end else begin
                        tx_shift_n = {tx_shift_q[5:0], 1'b1};
                        oe_n       = ~tx_shift_q[6];
                        bit_cnt_n  = bit_cnt_q + 3'd1;
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync) state_n = WAIT_STOP;
                        else          slot_n  = 1'b1;
                    end else if (scl_fall && slot_q) begin
                        tx_shift_n = tx_next[6:0];
                        oe_n       = ~tx_next[7];
                        underrun_n = ~bus.i_TxValid;
                        slot_n     = 1'b0;
                        bit_cnt_n  = '0;
                        state_n    = TX_BYTE;
                    end
                end
                WAIT_STOP: oe_n = 1'b0;
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_SDA_OE     = oe_q;
    assign bus.o_RxData     = rx_data_q;
    assign bus.o_RxValid    = rx_valid_q;
    assign bus.o_TxReq      = tx_req_q;
    assign bus.o_TxUnderrun = underrun_q;
    assign bus.o_Busy       = matched_q && (state_q != IDLE) && (state_q != ADDR);
    assign o_State          = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master plus a transaction-level model of the responder.
module tb_i2c_slave;
    import i2c_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic m_scl;
    logic m_sda;
    logic rx_ready;
    logic tx_valid;
    logic [7:0] tx_data;
    stateType_I2C_Slave dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    i2c_slave_if bus();

    assign bus.i_SCL     = m_scl;
    assign bus.i_SDA     = m_sda & ~bus.o_SDA_OE;
    assign bus.i_RxReady = rx_ready;
    assign bus.i_TxValid = tx_valid;
    assign bus.i_TxData  = tx_data;

    i2c_slave #(.DataWidth(8), .SlaveAddress(7'h50), .SyncStages(2)) dut (
        .i_CLK    (clk),
        .i_RESET  (rst),
        .i_ENABLE (en),
        .bus      (bus.slave),
        .o_State  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    // ---------------- monitor (event counters) ----------------
    int rx_valid_cnt = 0;
    int tx_req_cnt   = 0;
    int underrun_cnt = 0;
    int oe_cnt       = 0;
    int busy_cnt     = 0;
    int glitch_cnt   = 0;
    logic oe_prev    = 1'b0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (bus.o_RxValid) begin
            rx_valid_cnt++;
            rx_log.push_back(bus.o_RxData);
        end
        if (bus.o_TxReq) tx_req_cnt++;
        if (bus.o_TxUnderrun) underrun_cnt++;
        if (bus.o_SDA_OE) oe_cnt++;
        if (bus.o_Busy) busy_cnt++;
        if (bus.o_SDA_OE && !oe_prev && m_scl) glitch_cnt++;
        oe_prev = bus.o_SDA_OE;
    end

    // ---------------- reference model ----------------
    function automatic logic model_addr_ack(input logic [7:0] ab, input logic enabled);
        return enabled && (ab[7:1] == 7'h50);
    endfunction

    function automatic logic [7:0] model_tx_byte(input logic [7:0] d, input logic v);
        return v ? d : 8'hFF;
    endfunction

    // ---------------- master driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        tick(1); m_sda = b;
        tick(4); m_scl = 1'b1;
        tick(3); r = bus.i_SDA;
        tick(2); m_scl = 1'b0;
    endtask

    task automatic bus_start();
        tick(1); m_sda = 1'b1;
        tick(4); m_scl = 1'b1;
        tick(4); m_sda = 1'b0;
        tick(4); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(1); m_sda = 1'b0;
        tick(4); m_scl = 1'b1;
        tick(4); m_sda = 1'b1;
        tick(6);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic run_write(input logic [7:0] ab, input logic [7:0] d[4], input int n,
                             input logic [3:0] rdy, output logic addr_ack, output logic [3:0] acks);
        logic a;
        acks = '0;
        bus_start();
        write_byte(ab, addr_ack);
        for (int i = 0; i < n; i++) begin
            rx_ready = rdy[i];
            write_byte(d[i], a);
            acks[i] = a;
        end
        bus_stop();
        rx_ready = 1'b1;
    endtask

    task automatic run_read(input logic [7:0] d[4], input logic [3:0] v, input int n,
                            output logic addr_ack, output logic [7:0] got[4],
                            output logic oe_after, output stateType_I2C_Slave st_after);
        logic r;
        logic [7:0] b;
        tx_data  = d[0];
        tx_valid = v[0];
        bus_start();
        write_byte(8'hA1, addr_ack);
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                bus_bit(1'b1, r);
                b[k] = r;
            end
            got[i] = b;
            if (i + 1 < n) begin
                tx_data  = d[i+1];
                tx_valid = v[i+1];
            end
            bus_bit(i == n - 1, r);
        end
        tick(2);
        oe_after = bus.o_SDA_OE;
        st_after = dbg_state;
        bus_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        n_tests++; if (bus.o_SDA_OE !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", bus.o_SDA_OE); end
        n_tests++; if (bus.o_RxData !== 8'h00) begin n_fail++; $display("FAIL reset_rxdata got=%h exp=00", bus.o_RxData); end
        n_tests++; if ({bus.o_RxValid, bus.o_TxReq, bus.o_TxUnderrun, bus.o_Busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {bus.o_RxValid, bus.o_TxReq, bus.o_TxUnderrun, bus.o_Busy});
        end
    endtask

    task automatic test_write(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [7:0] d[4];
            logic [3:0] rdy, acks;
            logic aa;
            int n, rx0, busy0, gl0, idx, n_exp;
            logic [7:0] e, g;
            if (it == 0) begin
                n = 1; d[0] = 8'h3C; rdy = 4'hF;
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
                rdy = 4'($urandom_range(0, 15)) | 4'b0001;
            end
            n_exp = 0;
            for (int k = 0; k < n; k++) if (rdy[k]) begin exp_q.push_back(d[k]); n_exp++; end
            rx0 = rx_valid_cnt; busy0 = busy_cnt; gl0 = glitch_cnt; idx = rx_log.size();
            run_write(8'hA0, d, n, rdy, aa, acks);
            n_tests++; if (aa !== model_addr_ack(8'hA0, 1'b1)) begin n_fail++; $display("FAIL write_addr_ack it=%0d got=%b exp=1", it, aa); end
            for (int k = 0; k < n; k++) begin
                n_tests++; if (acks[k] !== rdy[k]) begin n_fail++; $display("FAIL write_data_ack it=%0d byte=%0d got=%b exp=%b", it, k, acks[k], rdy[k]); end
            end
            n_tests++; if (rx_valid_cnt - rx0 !== n_exp) begin n_fail++; $display("FAIL write_rxvalid_count it=%0d got=%0d exp=%0d", it, rx_valid_cnt - rx0, n_exp); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (idx < rx_log.size()) ? rx_log[idx] : 8'hxx;
                idx++;
                n_tests++; if (g !== e) begin n_fail++; $display("FAIL write_rx_data it=%0d got=%h exp=%h", it, g, e); end
            end
            n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL write_idle_after_stop it=%0d got=%0d exp=%0d", it, dbg_state, IDLE); end
            n_tests++; if ((busy_cnt > busy0) !== 1'b1) begin n_fail++; $display("FAIL write_busy_seen it=%0d got=0 exp=1", it); end
            n_tests++; if (glitch_cnt - gl0 !== 0) begin n_fail++; $display("FAIL write_oe_scl_high it=%0d got=%0d exp=0", it, glitch_cnt - gl0); end
        end
    endtask

    task automatic test_wrong_addr();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] d[4], ab;
            logic [3:0] acks;
            logic aa;
            int oe0, rx0, busy0;
            if (it == 0) ab = 8'hA2;
            else begin
                ab = 8'($urandom_range(0, 255));
                if (ab[7:1] == 7'h50) ab[7:1] = 7'h51;
            end
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
            oe0 = oe_cnt; rx0 = rx_valid_cnt; busy0 = busy_cnt;
            run_write(ab, d, 2, 4'hF, aa, acks);
            n_tests++; if (aa !== model_addr_ack(ab, 1'b1)) begin n_fail++; $display("FAIL wrong_addr_ack ab=%h got=%b exp=0", ab, aa); end
            n_tests++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL wrong_addr_oe ab=%h got=%0d exp=0", ab, oe_cnt - oe0); end
            n_tests++; if (rx_valid_cnt - rx0 !== 0) begin n_fail++; $display("FAIL wrong_addr_rxvalid ab=%h got=%0d exp=0", ab, rx_valid_cnt - rx0); end
            n_tests++; if (busy_cnt - busy0 !== 0) begin n_fail++; $display("FAIL wrong_addr_busy ab=%h got=%0d exp=0", ab, busy_cnt - busy0); end
        end
    endtask

    task automatic test_read(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [7:0] d[4], got[4];
            logic [3:0] v;
            logic aa, oe_after;
            stateType_I2C_Slave st;
            int n, req0, und0, n_und;
            if (it == 0) begin
                n = 2; d[0] = 8'hA5; d[1] = 8'h00; v = 4'b0001;
            end else begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
                v = 4'($urandom_range(0, 15));
            end
            n_und = 0;
            for (int k = 0; k < n; k++) if (!v[k]) n_und++;
            req0 = tx_req_cnt; und0 = underrun_cnt;
            run_read(d, v, n, aa, got, oe_after, st);
            n_tests++; if (aa !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack it=%0d got=%b exp=1", it, aa); end
            for (int k = 0; k < n; k++) begin
                n_tests++; if (got[k] !== model_tx_byte(d[k], v[k])) begin
                    n_fail++; $display("FAIL read_data it=%0d byte=%0d got=%h exp=%h", it, k, got[k], model_tx_byte(d[k], v[k]));
                end
            end
            n_tests++; if (tx_req_cnt - req0 !== n + 1) begin n_fail++; $display("FAIL read_txreq_count it=%0d got=%0d exp=%0d", it, tx_req_cnt - req0, n + 1); end
            n_tests++; if (underrun_cnt - und0 !== n_und) begin n_fail++; $display("FAIL read_underrun_count it=%0d got=%0d exp=%0d", it, underrun_cnt - und0, n_und); end
            n_tests++; if (oe_after !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack it=%0d got=%b exp=0", it, oe_after); end
            n_tests++; if (st !== WAIT_STOP) begin n_fail++; $display("FAIL read_wait_stop it=%0d got=%0d exp=%0d", it, st, WAIT_STOP); end
            n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL read_idle_after_stop it=%0d got=%0d exp=%0d", it, dbg_state, IDLE); end
        end
    endtask

    task automatic test_rx_not_ready();
        logic [7:0] d[4];
        logic [3:0] acks;
        logic aa;
        int rx0;
        d[0] = 8'h12; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
        rx0 = rx_valid_cnt;
        run_write(8'hA0, d, 1, 4'b0000, aa, acks);
        n_tests++; if (aa !== 1'b1) begin n_fail++; $display("FAIL not_ready_addr_ack got=%b exp=1", aa); end
        n_tests++; if (acks[0] !== 1'b0) begin n_fail++; $display("FAIL not_ready_nack got=%b exp=0", acks[0]); end
        n_tests++; if (rx_valid_cnt - rx0 !== 0) begin n_fail++; $display("FAIL not_ready_rxvalid got=%0d exp=0", rx_valid_cnt - rx0); end
    endtask

    task automatic test_repeated_start();
        logic aa, r, oe_after;
        logic [7:0] b, exp_b;
        int rx0, req0;
        exp_b = 8'($urandom_range(0, 255));
        rx0 = rx_valid_cnt; req0 = tx_req_cnt;
        bus_start();
        write_byte(8'hA0, aa);
        n_tests++; if (aa !== 1'b1) begin n_fail++; $display("FAIL rs_write_addr_ack got=%b exp=1", aa); end
        for (int k = 0; k < 4; k++) bus_bit(1'($urandom_range(0, 1)), r);
        tx_data = exp_b; tx_valid = 1'b1;
        bus_start();
        write_byte(8'hA1, aa);
        n_tests++; if (aa !== 1'b1) begin n_fail++; $display("FAIL rs_read_addr_ack got=%b exp=1", aa); end
        for (int k = 7; k >= 0; k--) begin bus_bit(1'b1, r); b[k] = r; end
        bus_bit(1'b1, r);
        tick(2);
        oe_after = bus.o_SDA_OE;
        bus_stop();
        n_tests++; if (b !== exp_b) begin n_fail++; $display("FAIL rs_read_data got=%h exp=%h", b, exp_b); end
        n_tests++; if (oe_after !== 1'b0) begin n_fail++; $display("FAIL rs_release got=%b exp=0", oe_after); end
        n_tests++; if (rx_valid_cnt - rx0 !== 0) begin n_fail++; $display("FAIL rs_no_rxvalid got=%0d exp=0", rx_valid_cnt - rx0); end
        n_tests++; if (tx_req_cnt - req0 !== 2) begin n_fail++; $display("FAIL rs_txreq_count got=%0d exp=2", tx_req_cnt - req0); end
    endtask

    task automatic test_reset_mid();
        logic aa;
        logic [7:0] d[4];
        logic [3:0] acks;
        int rx0;
        tx_data = 8'h3C; tx_valid = 1'b1;
        bus_start();
        write_byte(8'hA1, aa);
        tick(4);
        n_tests++; if (bus.o_SDA_OE !== 1'b1) begin n_fail++; $display("FAIL rstmid_driving_zero got=%b exp=1", bus.o_SDA_OE); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_tests++; if (bus.o_SDA_OE !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe got=%b exp=0", bus.o_SDA_OE); end
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rstmid_state got=%0d exp=%0d", dbg_state, IDLE); end
        bus_stop();
        d[0] = 8'($urandom_range(0, 255)); d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
        rx0 = rx_valid_cnt;
        run_write(8'hA0, d, 1, 4'b0001, aa, acks);
        n_tests++; if ({aa, acks[0]} !== 2'b11) begin n_fail++; $display("FAIL rstmid_write_acks got=%b exp=11", {aa, acks[0]}); end
        n_tests++; if (rx_valid_cnt - rx0 !== 1) begin n_fail++; $display("FAIL rstmid_rxvalid got=%0d exp=1", rx_valid_cnt - rx0); end
        n_tests++; if (bus.o_RxData !== d[0]) begin n_fail++; $display("FAIL rstmid_rxdata got=%h exp=%h", bus.o_RxData, d[0]); end
    endtask

    task automatic test_disable();
        logic [7:0] d[4];
        logic [3:0] acks;
        logic aa;
        int oe0, rx0;
        for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
        en = 1'b0;
        oe0 = oe_cnt; rx0 = rx_valid_cnt;
        run_write(8'hA0, d, 1, 4'b0001, aa, acks);
        n_tests++; if (aa !== model_addr_ack(8'hA0, 1'b0)) begin n_fail++; $display("FAIL disable_addr_ack got=%b exp=0", aa); end
        n_tests++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL disable_oe got=%0d exp=0", oe_cnt - oe0); end
        n_tests++; if (rx_valid_cnt - rx0 !== 0) begin n_fail++; $display("FAIL disable_rxvalid got=%0d exp=0", rx_valid_cnt - rx0); end
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL disable_state got=%0d exp=%0d", dbg_state, IDLE); end
        en = 1'b1;
        tick(4);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        test_reset();
        test_write(4);
        test_wrong_addr();
        test_read(3);
        test_rx_not_ready();
        test_repeated_start();
        test_reset_mid();
        test_disable();
        test_write(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
